// File: rtl/rv32_pkg.sv
// RV32I encoding constants, class bit indices and the decoded-bundle type
// shared by the decode stage and its combinational decoder.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_JALR  = 3'b000;
  localparam logic [2:0] F3_FENCE = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_PRIV     = 3'b000;
  localparam logic [2:0] F3_CSR_RSVD = 3'b100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam int CLS_ALU    = 0;
  localparam int CLS_BRANCH = 1;
  localparam int CLS_JAL    = 2;
  localparam int CLS_JALR   = 3;
  localparam int CLS_LOAD   = 4;
  localparam int CLS_STORE  = 5;
  localparam int CLS_CSR    = 6;
  localparam int CLS_SYSTEM = 7;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_we;
    logic [7:0]  cls;
    logic        illegal;
  } id_bundle_t;

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I word-to-bundle decoder; illegal words keep their
// raw register fields but carry no class, immediate or operand use.
module rv32_decode_comb
  import rv32_pkg::*;
#(
  parameter int ZICSR_EN = 1
) (
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output id_bundle_t  bundle_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        legal;
  logic [31:0] imm;
  logic        rs1_used;
  logic        rs2_used;
  logic        rd_we;
  logic [7:0]  cls;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  always_comb begin
    legal    = 1'b0;
    imm      = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    rd_we    = 1'b0;
    cls      = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        legal = 1'b1; imm = imm_u(inst_i); rd_we = 1'b1; cls[CLS_ALU] = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; imm = imm_j(inst_i); rd_we = 1'b1; cls[CLS_JAL] = 1'b1;
      end
      OPC_JALR: begin
        legal = (funct3 == F3_JALR); imm = imm_i(inst_i);
        rs1_used = 1'b1; rd_we = 1'b1; cls[CLS_JALR] = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE) || (funct3 == F3_BLT) ||
                (funct3 == F3_BGE) || (funct3 == F3_BLTU) || (funct3 == F3_BGEU);
        imm = imm_b(inst_i); rs1_used = 1'b1; rs2_used = 1'b1; cls[CLS_BRANCH] = 1'b1;
      end
      OPC_LOAD: begin
        legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                (funct3 == F3_LBU) || (funct3 == F3_LHU);
        imm = imm_i(inst_i); rs1_used = 1'b1; rd_we = 1'b1; cls[CLS_LOAD] = 1'b1;
      end
      OPC_STORE: begin
        legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        imm = imm_s(inst_i); rs1_used = 1'b1; rs2_used = 1'b1; cls[CLS_STORE] = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only the shift forms constrain funct7; the rest use those bits as immediate.
        if (funct3 == F3_SLL)     legal = (funct7 == F7_BASE);
        else if (funct3 == F3_SR) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                      legal = 1'b1;
        imm = imm_i(inst_i); rs1_used = 1'b1; rd_we = 1'b1; cls[CLS_ALU] = 1'b1;
      end
      OPC_OP: begin
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
        rs1_used = 1'b1; rs2_used = 1'b1; rd_we = 1'b1; cls[CLS_ALU] = 1'b1;
      end
      OPC_MISC_MEM: begin
        legal = (funct3 == F3_FENCE); cls[CLS_ALU] = 1'b1;
      end
      OPC_SYSTEM: begin
        if (funct3 == F3_PRIV) begin
          legal = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK) || (inst_i == INST_MRET);
          cls[CLS_SYSTEM] = 1'b1;
        end else begin
          // funct3[2] selects the immediate CSR forms, whose rs1 field is a uimm.
          legal = (ZICSR_EN != 0) && (funct3 != F3_CSR_RSVD);
          rs1_used = !funct3[2]; rd_we = 1'b1; cls[CLS_CSR] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bundle_o.pc       = pc_i;
  assign bundle_o.inst     = inst_i;
  assign bundle_o.rd       = inst_i[11:7];
  assign bundle_o.rs1      = inst_i[19:15];
  assign bundle_o.rs2      = inst_i[24:20];
  assign bundle_o.imm      = legal ? imm : '0;
  assign bundle_o.rs1_used = legal && rs1_used;
  assign bundle_o.rs2_used = legal && rs2_used;
  assign bundle_o.rd_we    = legal && rd_we && (inst_i[11:7] != 5'd0);
  assign bundle_o.cls      = legal ? cls : '0;
  assign bundle_o.illegal  = !legal;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: circular instruction FIFO feeding a registered decoded bundle
// with valid/ready handshakes on both sides and a synchronous flush.
module decode_stage
  import rv32_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter int          ZICSR_EN     = 1,
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     if_valid_i,
  output logic                     if_ready_o,
  input  logic [31:0]              if_inst_i,
  input  logic [31:0]              if_pc_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [31:0]              id_pc_o,
  output logic [31:0]              id_inst_o,
  output logic [4:0]               id_rd_addr_o,
  output logic [4:0]               id_rs1_addr_o,
  output logic [4:0]               id_rs2_addr_o,
  output logic [31:0]              id_imm_o,
  output logic                     id_rs1_used_o,
  output logic                     id_rs2_used_o,
  output logic                     id_rd_we_o,
  output logic [7:0]               id_class_o,
  output logic                     id_illegal_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;
  logic          head_load;
  logic          out_valid;
  id_bundle_t    head_dec;
  id_bundle_t    out_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign if_ready_o = (count < (PW+1)'(DEPTH));
  assign push       = if_valid_i && if_ready_o && !flush_i;
  assign pop        = out_valid && id_ready_i;
  assign head_load  = (count != '0) && (!out_valid || pop);

  // Storage is deliberately left unreset; the pointers define what is live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_mem[wr_ptr] <= if_inst_i;
      pc_mem[wr_ptr]   <= if_pc_i;
    end
  end

  rv32_decode_comb #(.ZICSR_EN(ZICSR_EN)) u_decode (
    .inst_i   (inst_mem[rd_ptr]),
    .pc_i     (pc_mem[rd_ptr]),
    .bundle_o (head_dec)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush_i) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (head_load) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + (PW+1)'(push) - (PW+1)'(head_load);
      if (head_load) begin
        out_valid <= 1'b1;
        out_q     <= head_dec;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Outputs are masked by valid so an idle stage always shows the tag PC and zeros.
  assign id_valid_o    = out_valid;
  assign id_pc_o       = out_valid ? out_q.pc : RESET_PC_TAG;
  assign id_inst_o     = out_valid ? out_q.inst : '0;
  assign id_rd_addr_o  = out_valid ? out_q.rd : '0;
  assign id_rs1_addr_o = out_valid ? out_q.rs1 : '0;
  assign id_rs2_addr_o = out_valid ? out_q.rs2 : '0;
  assign id_imm_o      = out_valid ? out_q.imm : '0;
  assign id_rs1_used_o = out_valid && out_q.rs1_used;
  assign id_rs2_used_o = out_valid && out_q.rs2_used;
  assign id_rd_we_o    = out_valid && out_q.rd_we;
  assign id_class_o    = out_valid ? out_q.cls : '0;
  assign id_illegal_o  = out_valid && out_q.illegal;
  assign occupancy_o   = count;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: randomized and directed pushes are modelled
// from the RV32I rules; a second instance covers the ZICSR_EN=0 build.
module tb_decode_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] TAG   = 32'hDEAD_0000;

  logic        clk;
  logic        rst_i, flush_i, if_valid_i, if_ready_o, id_valid_o, id_ready_i;
  logic [31:0] if_inst_i, if_pc_i, id_pc_o, id_inst_o, id_imm_o;
  logic [4:0]  id_rd_addr_o, id_rs1_addr_o, id_rs2_addr_o;
  logic        id_rs1_used_o, id_rs2_used_o, id_rd_we_o, id_illegal_o;
  logic [7:0]  id_class_o;
  logic [$clog2(DEPTH):0] occupancy_o;

  logic        n_flush, n_if_valid, n_if_ready, n_id_valid, n_id_ready;
  logic [31:0] n_if_inst, n_if_pc, n_id_pc, n_id_inst, n_id_imm;
  logic [4:0]  n_rd, n_rs1, n_rs2;
  logic        n_rs1_used, n_rs2_used, n_rd_we, n_illegal;
  logic [7:0]  n_class;
  logic [$clog2(DEPTH):0] n_occupancy;

  logic [127:0] sb[$];
  int compared, mismatched, popCount;

  decode_stage #(.DEPTH(DEPTH), .ZICSR_EN(1), .RESET_PC_TAG(TAG)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_inst_i(if_inst_i), .if_pc_i(if_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .id_rd_addr_o(id_rd_addr_o), .id_rs1_addr_o(id_rs1_addr_o), .id_rs2_addr_o(id_rs2_addr_o),
    .id_imm_o(id_imm_o), .id_rs1_used_o(id_rs1_used_o), .id_rs2_used_o(id_rs2_used_o),
    .id_rd_we_o(id_rd_we_o), .id_class_o(id_class_o), .id_illegal_o(id_illegal_o),
    .occupancy_o(occupancy_o)
  );

  decode_stage #(.DEPTH(DEPTH), .ZICSR_EN(0)) dut_nocsr (
    .clk_i(clk), .rst_i(rst_i), .flush_i(n_flush),
    .if_valid_i(n_if_valid), .if_ready_o(n_if_ready), .if_inst_i(n_if_inst), .if_pc_i(n_if_pc),
    .id_valid_o(n_id_valid), .id_ready_i(n_id_ready), .id_pc_o(n_id_pc), .id_inst_o(n_id_inst),
    .id_rd_addr_o(n_rd), .id_rs1_addr_o(n_rs1), .id_rs2_addr_o(n_rs2),
    .id_imm_o(n_id_imm), .id_rs1_used_o(n_rs1_used), .id_rs2_used_o(n_rs2_used),
    .id_rd_we_o(n_rd_we), .id_class_o(n_class), .id_illegal_o(n_illegal),
    .occupancy_o(n_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundle straight from the RV32I encoding rules.
  function automatic logic [127:0] modelDecode(input logic [31:0] w, input logic [31:0] pc, input bit zicsr);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] immI, immS, immB, immU, immJ, imm;
    bit          ok, r1, r2, wr;
    int          clsBit;
    logic [7:0]  clsv;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    immI = 32'($signed(w) >>> 20);
    immS = (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
    immB = (32'($signed(w) >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    immU = w & 32'hFFFF_F000;
    immJ = (32'($signed(w) >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    ok = 0; r1 = 0; r2 = 0; wr = 0; imm = 0; clsBit = 0;
    case (op)
      7'h37, 7'h17: begin ok = 1; imm = immU; wr = 1; clsBit = 0; end
      7'h6f: begin ok = 1; imm = immJ; wr = 1; clsBit = 2; end
      7'h67: begin ok = (f3 == 0); imm = immI; r1 = 1; wr = 1; clsBit = 3; end
      7'h63: begin ok = (f3 != 2 && f3 != 3); imm = immB; r1 = 1; r2 = 1; clsBit = 1; end
      7'h03: begin ok = (f3 != 3 && f3 != 6 && f3 != 7); imm = immI; r1 = 1; wr = 1; clsBit = 4; end
      7'h23: begin ok = (f3 <= 2); imm = immS; r1 = 1; r2 = 1; clsBit = 5; end
      7'h13: begin
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1;
        imm = immI; r1 = 1; wr = 1; clsBit = 0;
      end
      7'h33: begin ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); r1 = 1; r2 = 1; wr = 1; clsBit = 0; end
      7'h0f: begin ok = (f3 == 0); clsBit = 0; end
      7'h73: begin
        if (f3 == 0) begin
          ok = (w == 32'h0000_0073) || (w == 32'h0010_0073) || (w == 32'h3020_0073); clsBit = 7;
        end else begin
          ok = zicsr && (f3 != 4); r1 = (f3 < 4); wr = 1; clsBit = 6;
        end
      end
      default: ok = 0;
    endcase
    if (!ok) begin imm = 0; r1 = 0; r2 = 0; wr = 0; end
    if (w[11:7] == 0) wr = 0;
    clsv = ok ? (8'h01 << clsBit) : 8'h00;
    return {5'b0, pc, w, w[11:7], w[19:15], w[24:20], imm, r1, r2, wr, clsv, !ok};
  endfunction

  function automatic logic [127:0] dutBundle();
    return {5'b0, id_pc_o, id_inst_o, id_rd_addr_o, id_rs1_addr_o, id_rs2_addr_o, id_imm_o,
            id_rs1_used_o, id_rs2_used_o, id_rd_we_o, id_class_o, id_illegal_o};
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 15);
    case (sel)
      0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6f;  3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7, 8: w[6:0] = 7'h13;
      9, 10: w[6:0] = 7'h33;  11: w[6:0] = 7'h0f;  12: w[6:0] = 7'h73;
      13: case ($urandom_range(0, 2))
            0: w = 32'h0000_0073;
            1: w = 32'h0010_0073;
            default: w = 32'h3020_0073;
          endcase
      default: ;
    endcase
    if (sel <= 12 && $urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ((sel == 3 || sel == 11) && $urandom_range(0, 1) == 1) w[14:12] = 3'b000;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    if_valid_i = v; if_inst_i = inst; if_pc_i = pc; id_ready_i = rdy; flush_i = fl;
    @(posedge clk); #1;
  endtask

  task automatic pushWord(input logic [31:0] inst, input logic [31:0] pc, input logic rdy);
    int tries = 0;
    while (!if_ready_o && tries < 50) begin
      applyStimulus(1'b0, 32'h0, 32'h0, rdy, 1'b0);
      tries++;
    end
    if (!if_ready_o) checkOutput("push_timeout", if_ready_o, 1);
    else applyStimulus(1'b1, inst, pc, rdy, 1'b0);
    if_valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n++;
    end
    checkOutput("drain_left", sb.size(), 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  // Recorder: every accepted push becomes an expected bundle; flush empties the queue.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (flush_i) sb.delete();
      else if (if_valid_i && if_ready_o) sb.push_back(modelDecode(if_inst_i, if_pc_i, 1'b1));
    end
  end

  // Monitor: a valid bundle must equal the oldest expectation until it is taken.
  always @(negedge clk) begin
    if (!rst_i && !flush_i) begin
      if (id_valid_o) begin
        if (sb.size() == 0) begin
          compared++; mismatched++;
          $display("[TB] FAIL spurious_bundle: got pc=%h inst=%h, required no bundle", id_pc_o, id_inst_o);
        end else begin
          checkOutput("bundle", dutBundle(), sb[0]);
          if (id_ready_i) begin
            void'(sb.pop_front());
            popCount++;
          end
        end
      end else begin
        checkOutput("idle_fields", dutBundle(), {5'b0, TAG, 91'b0});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] first;
    int base;
    compared = 0; mismatched = 0; popCount = 0;
    rst_i = 1'b1; flush_i = 0; if_valid_i = 0; if_inst_i = 0; if_pc_i = 0; id_ready_i = 0;
    n_flush = 0; n_if_valid = 0; n_if_inst = 0; n_if_pc = 0; n_id_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset_valid", id_valid_o, 0);
    checkOutput("reset_occupancy", occupancy_o, 0);
    checkOutput("reset_ready", if_ready_o, 1);
    checkOutput("reset_pc_tag", id_pc_o, TAG);

    $display("[TB] single addi latency");
    applyStimulus(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
    if_valid_i = 1'b0;
    checkOutput("addi_not_early", id_valid_o, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("addi_valid", id_valid_o, 1);
    checkOutput("addi_imm", id_imm_o, 32'd5);
    checkOutput("addi_rd", id_rd_addr_o, 5'd1);
    checkOutput("addi_rd_we", id_rd_we_o, 1);
    checkOutput("addi_class", id_class_o, 8'h01);
    waitDrain();

    $display("[TB] backpressure fill");
    first = randInst();
    pushWord(first, 32'h1000, 1'b0);
    for (int i = 1; i <= DEPTH; i++) pushWord(randInst(), 32'h1000 + 32'(4 * i), 1'b0);
    checkOutput("full_occupancy", occupancy_o, DEPTH);
    checkOutput("full_ready", if_ready_o, 0);
    checkOutput("full_hold_inst", id_inst_o, first);
    applyStimulus(1'b1, 32'h0000_0013, 32'h2000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0013, 32'h2004, 1'b0, 1'b0);
    if_valid_i = 1'b0;
    checkOutput("full_hold_after", id_inst_o, first);
    checkOutput("full_occupancy_after", occupancy_o, DEPTH);
    waitDrain();

    $display("[TB] back-to-back throughput");
    base = popCount;
    for (int i = 0; i < 16; i++) begin
      checkOutput("tput_ready", if_ready_o, 1);
      applyStimulus(1'b1, randInst(), 32'h3000 + 32'(4 * i), 1'b1, 1'b0);
    end
    if_valid_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("tput_count", popCount - base, 16);
    waitDrain();

    $display("[TB] flush with concurrent push");
    for (int i = 0; i < 3; i++) pushWord(randInst(), 32'h4000 + 32'(4 * i), 1'b0);
    applyStimulus(1'b1, 32'h0010_0113, 32'h4100, 1'b0, 1'b1);
    if_valid_i = 1'b0; flush_i = 1'b0;
    checkOutput("flush_valid", id_valid_o, 0);
    checkOutput("flush_occupancy", occupancy_o, 0);
    checkOutput("flush_ready", if_ready_o, 1);
    repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] csr with and without zicsr");
    n_if_valid = 1'b1; n_if_inst = 32'h3000_2073; n_if_pc = 32'h500;
    @(posedge clk); #1 n_if_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("nocsr_valid", n_id_valid, 1);
    checkOutput("nocsr_illegal", n_illegal, 1);
    checkOutput("nocsr_bundle",
                {5'b0, n_id_pc, n_id_inst, n_rd, n_rs1, n_rs2, n_id_imm, n_rs1_used, n_rs2_used, n_rd_we, n_class, n_illegal},
                modelDecode(32'h3000_2073, 32'h500, 1'b0));
    pushWord(32'h3000_2073, 32'h600, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("csr_class", id_class_o, 8'h40);
    checkOutput("csr_illegal", id_illegal_o, 0);
    waitDrain();

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 3; i++) pushWord(randInst(), 32'h5000 + 32'(4 * i), 1'b0);
    #2 rst_i = 1'b1;
    #1;
    sb.delete();
    checkOutput("areset_valid", id_valid_o, 0);
    checkOutput("areset_occupancy", occupancy_o, 0);
    checkOutput("areset_pc_tag", id_pc_o, TAG);
    @(posedge clk); #1 rst_i = 1'b0;
    checkOutput("areset_ready", if_ready_o, 1);
    pushWord(32'h0070_0193, 32'h700, 1'b1);
    waitDrain();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      logic v, rdy, fl;
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      if (fl) rdy = 1'b0;
      applyStimulus(v, randInst(), $urandom & 32'hFFFF_FFFC, rdy, fl);
    end
    if_valid_i = 1'b0; flush_i = 1'b0;
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
